// File: rtl/boot_sequencer.sv
`timescale 1ns/1ps
// boot_sequencer: run control for the cached core top -- reset hold,
// single start pulse, halt / watchdog detection and run-length count.
module boot_sequencer #(
    parameter int ADDRESS_BITS = 32,
    parameter logic [ADDRESS_BITS-1:0] PROGRAM_ADDRESS = '0,
    parameter logic [ADDRESS_BITS-1:0] HALT_ADDRESS = 'h0000_00FC,
    parameter int HALT_CONFIRM = 4,
    parameter int RESET_CYCLES = 16,
    parameter int WATCHDOG_CYCLES = 1024,
    parameter int CYCLE_BITS = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    go,
    input  logic                    abort,
    input  logic                    scan_req,
    input  logic [ADDRESS_BITS-1:0] PC,
    output logic                    core_reset,
    output logic                    start,
    output logic [ADDRESS_BITS-1:0] program_address,
    output logic                    scan,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [CYCLE_BITS-1:0]   cycle_count
);

    localparam int RW = $clog2(RESET_CYCLES + 1);
    localparam int HW = $clog2(HALT_CONFIRM + 1);
    localparam int SW = $clog2(WATCHDOG_CYCLES + 1);

    localparam logic [RW-1:0] RST_LOAD   = RW'(RESET_CYCLES);
    localparam logic [HW-1:0] HALT_MAX   = HW'(HALT_CONFIRM);
    localparam logic [SW-1:0] STALL_MAX  = SW'(WATCHDOG_CYCLES);
    localparam logic [SW-1:0] STALL_TRIP = SW'(WATCHDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_START,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t state;
    state_t next_state;

    logic [RW-1:0]           rst_cnt;
    logic [HW-1:0]           halt_cnt;
    logic [SW-1:0]           stall_cnt;
    logic [ADDRESS_BITS-1:0] last_pc;

    logic pc_same;
    logic halt_hit;
    logic stall_hit;
    logic enter_hold;
    logic run_step;

    assign program_address = PROGRAM_ADDRESS;

    assign pc_same    = (PC == last_pc);
    assign halt_hit   = (halt_cnt == HALT_MAX);
    assign stall_hit  = (stall_cnt == STALL_TRIP) && pc_same;
    assign enter_hold = (next_state == S_HOLD) && (state != S_HOLD);
    assign run_step   = (state == S_RUN) && !abort;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort && (state != S_IDLE)) begin
            next_state = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (go) next_state = S_HOLD;
                end
                S_HOLD: begin
                    if (rst_cnt == '0) next_state = S_START;
                end
                S_START: next_state = S_RUN;
                S_RUN: begin
                    if (halt_hit) begin
                        next_state = S_DONE;
                    end else if (stall_hit) begin
                        next_state = S_TIMEOUT;
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    // Counting RESET_CYCLES down to 0 keeps core_reset high for
    // RESET_CYCLES+1 cycles after the go edge before start rises.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_cnt <= '0;
        end else if (enter_hold) begin
            rst_cnt <= RST_LOAD;
        end else if ((state == S_HOLD) && (rst_cnt != '0)) begin
            rst_cnt <= rst_cnt - RW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
        end else if (enter_hold) begin
            cycle_count <= '0;
        end else if (run_step && (cycle_count != '1)) begin
            cycle_count <= cycle_count + CYCLE_BITS'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_pc   <= '0;
            stall_cnt <= '0;
            halt_cnt  <= '0;
        end else if (state == S_START) begin
            last_pc   <= PROGRAM_ADDRESS;
            stall_cnt <= '0;
            halt_cnt  <= '0;
        end else if (run_step) begin
            last_pc <= PC;
            if (!pc_same) begin
                stall_cnt <= '0;
            end else if (stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + SW'(1);
            end
            if (PC != HALT_ADDRESS) begin
                halt_cnt <= '0;
            end else if (halt_cnt != HALT_MAX) begin
                halt_cnt <= halt_cnt + HW'(1);
            end
        end
    end

    // Outputs follow next_state so they change on the same edge as state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            core_reset <= 1'b1;
            start      <= 1'b0;
            scan       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            core_reset <= !((next_state == S_START) ||
                            (next_state == S_RUN));
            start      <= (next_state == S_START);
            scan       <= (next_state == S_RUN) && scan_req;
            busy       <= (next_state == S_HOLD) ||
                          (next_state == S_START) ||
                          (next_state == S_RUN);
            done       <= (next_state == S_DONE);
            timeout    <= (next_state == S_TIMEOUT);
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
`timescale 1ns/1ps
// tb_boot_sequencer: directed and randomized runs of boot_sequencer
// against an index-arithmetic model of halt / watchdog exits.
module tb_boot_sequencer;

    localparam int          HC   = 4;
    localparam int          RC   = 16;
    localparam int          W    = 1024;
    localparam logic [31:0] PA   = 32'h0;
    localparam logic [31:0] HALT = 32'h0000_00FC;

    logic        clock = 1'b0;
    logic        reset;
    logic        go;
    logic        abort;
    logic        scan_req;
    logic [31:0] PC;
    logic        core_reset;
    logic        start;
    logic [31:0] program_address;
    logic        scan;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] cycle_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] seq[$];
    int          first_halt_k;
    int          exit_k;

    boot_sequencer #(
        .ADDRESS_BITS(32),
        .PROGRAM_ADDRESS(PA),
        .HALT_ADDRESS(HALT),
        .HALT_CONFIRM(HC),
        .RESET_CYCLES(RC),
        .WATCHDOG_CYCLES(W),
        .CYCLE_BITS(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .go(go),
        .abort(abort),
        .scan_req(scan_req),
        .PC(PC),
        .core_reset(core_reset),
        .start(start),
        .program_address(program_address),
        .scan(scan),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] sample(input int j);
        if (j < seq.size()) return seq[j];
        return seq[seq.size()-1];
    endfunction

    // kind 1 = halt, 2 = watchdog; len = RUN cycles incl. exit cycle
    function automatic void predict(output int kind, output int len);
        int          lastchg = -1;
        int          hrun = 0;
        logic [31:0] prev = PA;
        logic [31:0] s;
        kind = 0;
        len  = -2;
        for (int j = 0; j < seq.size() + W + HC + 16; j++) begin
            if (hrun >= HC) begin
                kind = 1;
                len  = j + 1;
                return;
            end
            s = sample(j);
            if (s != prev) lastchg = j;
            if (j - lastchg >= W) begin
                kind = 2;
                len  = j + 1;
                return;
            end
            hrun = (s == HALT) ? hrun + 1 : 0;
            prev = s;
        end
    endfunction

    task automatic ramp_to(input logic [31:0] last);
        seq.delete();
        for (int a = 0; a <= int'(last); a += 4) seq.push_back(32'(a));
    endtask

    task automatic gen_random();
        int nseg;
        int len;
        logic [31:0] v;
        seq.delete();
        nseg = $urandom_range(2, 6);
        for (int s = 0; s < nseg; s++) begin
            if ($urandom_range(0, 3) == 0) begin
                v   = HALT;
                len = $urandom_range(1, HC);
            end else begin
                v   = 32'($urandom_range(0, 62)) << 2;
                len = $urandom_range(1, 50);
            end
            for (int i = 0; i < len; i++) seq.push_back(v);
        end
        if ($urandom_range(0, 1) == 1) seq.push_back(HALT);
        else seq.push_back(32'($urandom_range(0, 62)) << 2);
    endtask

    // go pulse, reset hold, start pulse; returns in the first RUN cycle
    task automatic do_go();
        int n = 0;
        PC = PA;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("go_busy", busy, 1);
        chk("go_done_clr", done, 0);
        chk("go_timeout_clr", timeout, 0);
        chk("go_count_clr", cycle_count, 0);
        while (start !== 1'b1 && n < 4 * RC) begin
            chk("hold_core_reset", core_reset, 1);
            chk("hold_scan", scan, 0);
            n++;
            tick();
        end
        chk("hold_len", n, RC + 1);
        chk("start_core_reset", core_reset, 0);
        chk("start_busy", busy, 1);
        chk("start_scan", scan, 0);
        tick();
        chk("start_single", start, 0);
        chk("run_core_reset", core_reset, 0);
        chk("run_busy", busy, 1);
        chk("run_scan", scan, scan_req);
    endtask

    task automatic run_seq(input int go_at, input bit rnd_scan);
        int   k = 0;
        int   kind;
        int   len;
        bit   ended = 1'b0;
        logic req;
        int   limit;
        limit = seq.size() + W + HC + 16;
        first_halt_k = -1;
        exit_k = -1;
        predict(kind, len);
        while (!ended && k < limit) begin
            PC = sample(k);
            if (first_halt_k < 0 && PC == HALT) first_halt_k = k;
            go = (k == go_at);
            if (rnd_scan) scan_req = 1'($urandom_range(0, 1));
            req = scan_req;
            tick();
            go = 1'b0;
            if (done === 1'b1 || timeout === 1'b1) begin
                ended  = 1'b1;
                exit_k = k;
            end else begin
                chk("in_run_scan", scan, req);
                chk("in_run_busy", busy, 1);
                chk("in_run_core_reset", core_reset, 0);
                chk("in_run_start", start, 0);
                k++;
            end
        end
        chk("run_len", exit_k + 1, len);
        chk("exit_done", done, kind == 1);
        chk("exit_timeout", timeout, kind == 2);
        chk("exit_cycle_count", cycle_count, len);
        chk("exit_core_reset", core_reset, 1);
        chk("exit_busy", busy, 0);
        chk("exit_scan", scan, 0);
        chk("exit_start", start, 0);
        scan_req = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_core_reset"}, core_reset, 1);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_scan"}, scan, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_cycle_count"}, cycle_count, 0);
        chk({tag, "_prog_addr"}, program_address, PA);
    endtask

    initial begin
        int sp;
        reset    = 1'b1;
        go       = 1'b0;
        abort    = 1'b0;
        scan_req = 1'b1;
        PC       = '0;
        #2 reset = 1'b0;
        #1;
        chk_reset_vals("por");
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("idle_busy", busy, 0);
        chk("idle_core_reset", core_reset, 1);

        // ramp to halt address; go mid-run must be ignored
        do_go();
        ramp_to(HALT);
        run_seq(20, 1'b0);
        chk("halt_count_68", cycle_count, 68);
        chk("halt_latency", exit_k - first_halt_k, HC);
        tick();
        chk("done_sticky", done, 1);

        // go from DONE, PC stuck at 0x40 -> watchdog
        do_go();
        ramp_to(32'h40);
        run_seq(-1, 1'b0);

        // change on the last possible cycle before the watchdog trips
        do_go();
        ramp_to(32'h40);
        for (int i = 0; i < W - 1; i++) seq.push_back(32'h40);
        seq.push_back(32'h44);
        seq.push_back(32'h48);
        seq.push_back(HALT);
        run_seq(-1, 1'b0);
        chk("near_miss_no_timeout", timeout, 0);

        // abort during reset hold
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("ab_hold_done_clr", done, 0);
        for (int i = 0; i < 5; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_hold_busy", busy, 0);
        chk("ab_hold_core_reset", core_reset, 1);
        chk("ab_hold_done", done, 0);
        chk("ab_hold_timeout", timeout, 0);
        chk("ab_hold_count", cycle_count, 0);
        sp = 0;
        for (int i = 0; i < 2 * RC; i++) begin
            tick();
            if (start === 1'b1 || busy === 1'b1) sp++;
        end
        chk("ab_hold_no_start", sp, 0);

        // abort mid-run after 10 RUN cycles
        do_go();
        for (int k = 0; k < 10; k++) begin
            PC = 32'(8 * (k + 1));
            tick();
        end
        abort = 1'b1;
        PC = 32'h200;
        tick();
        abort = 1'b0;
        chk("ab_run_busy", busy, 0);
        chk("ab_run_core_reset", core_reset, 1);
        chk("ab_run_start", start, 0);
        chk("ab_run_scan", scan, 0);
        chk("ab_run_done", done, 0);
        chk("ab_run_timeout", timeout, 0);
        chk("ab_run_count", cycle_count, 10);
        for (int i = 0; i < 3; i++) tick();
        chk("ab_run_count_frozen", cycle_count, 10);
        chk("ab_run_idle_busy", busy, 0);

        // asynchronous reset between edges mid-run
        do_go();
        for (int k = 0; k < 5; k++) begin
            PC = 32'(4 * (k + 1));
            tick();
        end
        #3 reset = 1'b0;
        #1;
        chk_reset_vals("async");
        tick();
        tick();
        chk("async_held_busy", busy, 0);
        reset = 1'b1;
        tick();
        do_go();
        seq.delete();
        seq.push_back(HALT);
        run_seq(-1, 1'b0);
        chk("immediate_halt_count", cycle_count, HC + 1);

        // randomized programs with random scan requests
        for (int r = 0; r < 4; r++) begin
            gen_random();
            do_go();
            run_seq(int'($urandom_range(0, 40)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
